noc_router_1d: RTL
==================

# noc_router_1d

Buffered, parametrised successor to the single-register east/west NoC node. Each router sits in a linear chain of nodes with addresses increasing eastward. It adds per-direction input FIFOs, valid/ready back-pressure on every link, destination-based local ejection, local injection, and round-robin arbitration. A chain of routers is joined by connecting each router's east output to the next router's west input, and vice versa.

## Interface
- `DATA_W`, 8, payload width.
- `ADDR_W`, 4, destination/node address width.
- `NODE_ID`, 0, this router's address (`0 .. 2**ADDR_W-1`).
- `DEPTH`, 4, input FIFO depth per direction (power of two, ≥2).
- Flit = `{dest[ADDR_W], data[DATA_W]}`; `FLIT_W = ADDR_W+DATA_W`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `w_in_flit` in FLIT_W / `w_in_valid` in 1 / `w_in_ready` out 1: flits arriving from the west, travelling east.
- `e_in_flit` in FLIT_W / `e_in_valid` in 1 / `e_in_ready` out 1: flits arriving from the east, travelling west.
- `e_out_flit` out FLIT_W / `e_out_valid` out 1 / `e_out_ready` in 1: eastbound output.
- `w_out_flit` out FLIT_W / `w_out_valid` out 1 / `w_out_ready` in 1: westbound output.
- `inj_flit` in FLIT_W / `inj_valid` in 1 / `inj_ready` out 1: local injection.
- `ej_flit` out FLIT_W / `ej_valid` out 1 / `ej_ready` in 1: local ejection.
- `misroute` out 1: one-cycle pulse when a flit's destination lies behind its direction of travel.

## Operation
- **Transfer rule:** a transfer occurs when `valid && ready` at the rising clock edge. A source holds flit and valid stable until the transfer.
- **Input buffering:** each input writes into its own FIFO. `*_in_ready = !full`, derived from the registered count.
- **Routing of FIFO heads:** decided by the head's `dest`.
  - `dest == NODE_ID`: head requests eject.
  - Otherwise: head requests the output continuing its direction of travel.
- **Misroute:** a west-FIFO head with `dest < NODE_ID`, or an east-FIFO head with `dest > NODE_ID`, is still forwarded in its travel direction. `misroute` pulses on the cycle that head is dequeued.
- **Routing of injection:** `dest > NODE_ID` → east output; `dest < NODE_ID` → west output; `dest == NODE_ID` → eject (loopback). Injection is not buffered.
- **Output stages:** each output (east, west, eject) is a single register. It loads when `!out_valid || out_ready`, which gives full throughput.
- **Arbitration:**
  - East output: west-FIFO head vs injection.
  - West output: east-FIFO head vs injection.
  - Eject: west-FIFO head, east-FIFO head, injection.
  - Each arbiter is round-robin. Its pointer advances to the requester after the winner, only on a granted load.
  - Reset pointer: FIFO requester first.
- **Dequeue/ready:** a FIFO head is dequeued only on grant. `inj_ready` is combinational: high when injection wins its single target arbiter and that output stage can load.
- **Simultaneous enqueue and dequeue** on a full FIFO: the dequeue frees the slot, but `in_ready` stays low that cycle. No bypass.

## Timing
- **Reset:**
  - All `*_valid` outputs = 0.
  - All `*_flit` outputs = 0.
  - `misroute` = 0.
  - FIFOs empty and arbiter pointers reset.
  - `w_in_ready`, `e_in_ready` and `inj_ready` = 0 while `rst` is high; the input readys return to 1 on the first cycle after.
- **Reset mid-operation:** all buffered and in-flight flits are discarded. No partial transfers.
- **Through latency** (unblocked): input transfer at edge t → output valid after edge t+1, i.e. 2 cycles.
- **Injection latency:** transfer at edge t → output valid after edge t, i.e. 1 cycle.
- **Throughput:** each output sustains 1 flit/cycle with `out_ready` held high. Each input sustains 1 flit/cycle while its route is uncongested.
- **Back-pressure:** with `out_ready` low, the output holds flit and valid stable. The FIFO fills; `in_ready` drops the cycle after the DEPTH-th write.
- **FIFO pointers:** `log2(DEPTH)` bits, wrap modulo DEPTH. Count is `log2(DEPTH)+1` bits.

## Structure
- **Package `noc_pkg`:**
  - Default widths.
  - Parametrised flit struct helper (`dest`/`data` field extraction functions).
  - Direction enum `{DIR_E, DIR_W, DIR_L}`.
- **Sub-module `noc_fifo`:** parametrised width/depth synchronous FIFO with `full`, `empty`, `count`. It is instantiated twice.
- **Inline logic:** arbiters and output registers stay in the top module (about 250 lines total).

## Test plan
- **Pass-through east:** `NODE_ID=3`, w_in flit `{dest=7, data=0xA5}`, all readys high → `e_out` = `{7,0xA5}` exactly 2 cycles later; `ej_valid` stays 0.
- **Eject:** e_in `{dest=3, data=0x11}` → `ej_flit` = `{3,0x11}` after 2 cycles; `w_out_valid` stays 0.
- **Contention:**
  - Stimulus: w_in streams `dest=7` and inj streams `dest=9` every cycle.
  - Response: `e_out` alternates FIFO, inj, FIFO, inj; `inj_ready` is high on alternate cycles; no flit lost or duplicated.
- **Back-pressure:**
  - Stimulus: `e_out_ready=0` with `DEPTH=4`, 6 flits offered on w_in.
  - Response: 1 flit sits in the output register, 4 sit in the FIFO, and `w_in_ready` goes low; release `e_out_ready` → all 6 delivered in order.
- **Misroute/loopback:**
  - w_in `{dest=1}` → forwarded east, with a `misroute` pulse on dequeue.
  - inj `{dest=3}` → appears on `ej` after 1 cycle.
- **Reset mid-stream:** assert `rst` 1 cycle with FIFOs half full → all valids 0 next cycle; FIFOs empty; the first post-reset flit routes normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the 1-D NoC router: default widths, direction
// enum, a default-width flit struct, flit field helpers and the 3-way
// round-robin pick used by the eject arbiter.
package noc_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int NODE_ID_DEF = 0;

  typedef enum logic [1:0] {DIR_E, DIR_W, DIR_L} dir_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] data;
  } flit_def_t;

  // Flit layout is {dest, data}; callers zero-extend the flit to 64 bits
  // and narrow the result back to their own field width.
  function automatic logic [63:0] flit_dest(input logic [63:0] flit,
                                            input int data_w,
                                            input int addr_w);
    return (flit >> data_w) & ((64'd1 << addr_w) - 64'd1);
  endfunction

  function automatic logic [63:0] flit_data(input logic [63:0] flit,
                                            input int data_w);
    return flit & ((64'd1 << data_w) - 64'd1);
  endfunction

  // One-hot grant among three requesters, searching upward from ptr.
  function automatic logic [2:0] rr3_pick(input logic [2:0] req,
                                          input logic [1:0] ptr);
    logic [2:0] g;
    case (ptr)
      2'd1:    g = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      2'd2:    g = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
      default: g = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO, one per router input direction.
// Ports:
//   clk, rst         clock, synchronous active-high reset (empties FIFO)
//   wr_en_i/wr_data_i  write strobe and data (ignored when full)
//   rd_en_i            pop the head (ignored when empty)
//   rd_data_o          current head, valid while !empty_o
//   full_o/empty_o/count_o  occupancy, all from registered count
module noc_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed while count > 0.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/noc_router_1d.sv
// Buffered 1-D NoC router node with valid/ready links, local inject/eject
// and round-robin arbitration per output.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   w_in_*  (flit/valid/ready)        from west, travelling east (buffered)
//   e_in_*  (flit/valid/ready)        from east, travelling west (buffered)
//   e_out_*, w_out_*, ej_*            registered outputs east/west/local
//   inj_*   (flit/valid/ready)        local injection (unbuffered)
//   misroute                          pulse when a head travelling away
//                                     from its destination is dequeued
module noc_router_1d import noc_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NODE_ID = NODE_ID_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W+DATA_W-1:0] w_in_flit,
  input  logic                     w_in_valid,
  output logic                     w_in_ready,
  input  logic [ADDR_W+DATA_W-1:0] e_in_flit,
  input  logic                     e_in_valid,
  output logic                     e_in_ready,
  output logic [ADDR_W+DATA_W-1:0] e_out_flit,
  output logic                     e_out_valid,
  input  logic                     e_out_ready,
  output logic [ADDR_W+DATA_W-1:0] w_out_flit,
  output logic                     w_out_valid,
  input  logic                     w_out_ready,
  input  logic [ADDR_W+DATA_W-1:0] inj_flit,
  input  logic                     inj_valid,
  output logic                     inj_ready,
  output logic [ADDR_W+DATA_W-1:0] ej_flit,
  output logic                     ej_valid,
  input  logic                     ej_ready,
  output logic                     misroute
);

  localparam int FLIT_W = ADDR_W + DATA_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ME       = ADDR_W'(NODE_ID);

  logic run;
  assign run = !rst;

  // ---------------- input FIFOs ----------------
  logic              w_full, w_empty, e_full, e_empty;
  logic [PTR_W:0]    w_count, e_count;
  logic [FLIT_W-1:0] w_head, e_head;
  logic              w_wr, e_wr, w_deq, e_deq;

  assign w_in_ready = run && (w_count != CNT_FULL);
  assign e_in_ready = run && (e_count != CNT_FULL);
  assign w_wr       = w_in_valid && run && !w_full;
  assign e_wr       = e_in_valid && run && !e_full;

  noc_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo_w (
    .clk(clk), .rst(rst),
    .wr_en_i(w_wr), .wr_data_i(w_in_flit),
    .rd_en_i(w_deq), .rd_data_o(w_head),
    .full_o(w_full), .empty_o(w_empty), .count_o(w_count)
  );

  noc_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo_e (
    .clk(clk), .rst(rst),
    .wr_en_i(e_wr), .wr_data_i(e_in_flit),
    .rd_en_i(e_deq), .rd_data_o(e_head),
    .full_o(e_full), .empty_o(e_empty), .count_o(e_count)
  );

  // ---------------- routing requests ----------------
  logic [ADDR_W-1:0] w_dest, e_dest, inj_dest;
  dir_e              inj_dir;
  logic              w_req_e, w_req_l, e_req_w, e_req_l;
  logic              inj_req_e, inj_req_w, inj_req_l;

  assign w_dest   = ADDR_W'(flit_dest(64'(w_head),   DATA_W, ADDR_W));
  assign e_dest   = ADDR_W'(flit_dest(64'(e_head),   DATA_W, ADDR_W));
  assign inj_dest = ADDR_W'(flit_dest(64'(inj_flit), DATA_W, ADDR_W));

  // Buffered traffic never turns around: a head either ejects here or
  // keeps its travel direction, even when its destination is behind it.
  assign w_req_l = run && !w_empty && (w_dest == ME);
  assign w_req_e = run && !w_empty && (w_dest != ME);
  assign e_req_l = run && !e_empty && (e_dest == ME);
  assign e_req_w = run && !e_empty && (e_dest != ME);

  always_comb begin
    if (inj_dest > ME)      inj_dir = DIR_E;
    else if (inj_dest < ME) inj_dir = DIR_W;
    else                    inj_dir = DIR_L;
  end

  assign inj_req_e = run && inj_valid && (inj_dir == DIR_E);
  assign inj_req_w = run && inj_valid && (inj_dir == DIR_W);
  assign inj_req_l = run && inj_valid && (inj_dir == DIR_L);

  // ---------------- output stages and arbiters ----------------
  logic              e_out_valid_q, e_out_valid_d, w_out_valid_q, w_out_valid_d;
  logic              ej_valid_q, ej_valid_d;
  logic [FLIT_W-1:0] e_out_flit_q, e_out_flit_d, w_out_flit_q, w_out_flit_d;
  logic [FLIT_W-1:0] ej_flit_q, ej_flit_d;
  logic              e_ld, w_ld, j_ld;

  assign e_ld = !e_out_valid_q || e_out_ready;
  assign w_ld = !w_out_valid_q || w_out_ready;
  assign j_ld = !ej_valid_q    || ej_ready;

  // Two-way pointers: 0 = FIFO has priority, 1 = injection has priority.
  logic eo_ptr_q, eo_ptr_d, wo_ptr_q, wo_ptr_d;
  logic eo_gnt_fifo, eo_gnt_inj, wo_gnt_fifo, wo_gnt_inj;

  always_comb begin
    eo_gnt_fifo = 1'b0;
    eo_gnt_inj  = 1'b0;
    eo_ptr_d    = eo_ptr_q;
    if (e_ld) begin
      if (w_req_e && (!eo_ptr_q || !inj_req_e)) eo_gnt_fifo = 1'b1;
      else if (inj_req_e)                       eo_gnt_inj  = 1'b1;
    end
    if (eo_gnt_fifo)     eo_ptr_d = 1'b1;
    else if (eo_gnt_inj) eo_ptr_d = 1'b0;
  end

  always_comb begin
    wo_gnt_fifo = 1'b0;
    wo_gnt_inj  = 1'b0;
    wo_ptr_d    = wo_ptr_q;
    if (w_ld) begin
      if (e_req_w && (!wo_ptr_q || !inj_req_w)) wo_gnt_fifo = 1'b1;
      else if (inj_req_w)                       wo_gnt_inj  = 1'b1;
    end
    if (wo_gnt_fifo)     wo_ptr_d = 1'b1;
    else if (wo_gnt_inj) wo_ptr_d = 1'b0;
  end

  // Eject requesters: bit0 west FIFO, bit1 east FIFO, bit2 injection.
  logic [1:0] j_ptr_q, j_ptr_d;
  logic [2:0] j_req, j_gnt;

  assign j_req = {inj_req_l, e_req_l, w_req_l};
  assign j_gnt = j_ld ? rr3_pick(j_req, j_ptr_q) : 3'b000;

  always_comb begin
    case (j_gnt)
      3'b001:  j_ptr_d = 2'd1;
      3'b010:  j_ptr_d = 2'd2;
      3'b100:  j_ptr_d = 2'd0;
      default: j_ptr_d = j_ptr_q;
    endcase
  end

  assign w_deq     = eo_gnt_fifo || j_gnt[0];
  assign e_deq     = wo_gnt_fifo || j_gnt[1];
  assign inj_ready = eo_gnt_inj || wo_gnt_inj || j_gnt[2];
  assign misroute  = (w_deq && (w_dest < ME)) || (e_deq && (e_dest > ME));

  always_comb begin
    e_out_valid_d = e_out_valid_q;
    e_out_flit_d  = e_out_flit_q;
    w_out_valid_d = w_out_valid_q;
    w_out_flit_d  = w_out_flit_q;
    ej_valid_d    = ej_valid_q;
    ej_flit_d     = ej_flit_q;
    if (e_ld) begin
      e_out_valid_d = eo_gnt_fifo || eo_gnt_inj;
      if (eo_gnt_fifo)     e_out_flit_d = w_head;
      else if (eo_gnt_inj) e_out_flit_d = inj_flit;
    end
    if (w_ld) begin
      w_out_valid_d = wo_gnt_fifo || wo_gnt_inj;
      if (wo_gnt_fifo)     w_out_flit_d = e_head;
      else if (wo_gnt_inj) w_out_flit_d = inj_flit;
    end
    if (j_ld) begin
      ej_valid_d = |j_gnt;
      if (j_gnt[0])      ej_flit_d = w_head;
      else if (j_gnt[1]) ej_flit_d = e_head;
      else if (j_gnt[2]) ej_flit_d = inj_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_out_valid_q <= 1'b0;
      e_out_flit_q  <= '0;
      w_out_valid_q <= 1'b0;
      w_out_flit_q  <= '0;
      ej_valid_q    <= 1'b0;
      ej_flit_q     <= '0;
      eo_ptr_q      <= 1'b0;
      wo_ptr_q      <= 1'b0;
      j_ptr_q       <= 2'd0;
    end else begin
      e_out_valid_q <= e_out_valid_d;
      e_out_flit_q  <= e_out_flit_d;
      w_out_valid_q <= w_out_valid_d;
      w_out_flit_q  <= w_out_flit_d;
      ej_valid_q    <= ej_valid_d;
      ej_flit_q     <= ej_flit_d;
      eo_ptr_q      <= eo_ptr_d;
      wo_ptr_q      <= wo_ptr_d;
      j_ptr_q       <= j_ptr_d;
    end
  end

  assign e_out_valid = e_out_valid_q;
  assign e_out_flit  = e_out_flit_q;
  assign w_out_valid = w_out_valid_q;
  assign w_out_flit  = w_out_flit_q;
  assign ej_valid    = ej_valid_q;
  assign ej_flit     = ej_flit_q;

endmodule
